// File: rtl/watch_data_gen_pkg.sv
// watch_data_gen_pkg
// Shared definitions for the digital watch: mode encodings as seen on
// state_flag, time-field limits, BCD digit width and two-digit BCD helpers.
// No ports (package).
package watch_data_gen_pkg;

  localparam int DIGIT_W  = 4;
  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEC_MAX  = 59;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    SET_HOUR   = 3'd1,
    SET_MINUTE = 3'd2
  } mode_e;

  // Two-digit BCD encoding of a small integer (0..99).
  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Two-digit BCD increment that wraps from max back to 00.
  function automatic logic [7:0] bcd_up(input logic [7:0] v, input int max);
    if (v == to_bcd(max)) return 8'h00;
    if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Two-digit BCD decrement that wraps from 00 up to max.
  function automatic logic [7:0] bcd_down(input logic [7:0] v, input int max);
    if (v == 8'h00)       return to_bcd(max);
    if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/watch_data_gen_key_debounce.sv
// key_debounce
// Conditions one active-low raw push button: two-flop synchroniser, an
// optional stability filter, and a one-cycle pulse on the filtered
// high-to-low transition (so a held key yields exactly one pulse).
// Build option: WATCH_KEY_DEBOUNCE_EN enables the stability filter
// (parameter STABLE_CYC exists only in that build).
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   key   - raw active-low button
//   press - one-cycle press pulse
module key_debounce
`ifdef WATCH_KEY_DEBOUNCE_EN
#(
  parameter int STABLE_CYC = 2
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  logic sync1;
  logic sync2;
  logic filt;
  logic filt_prev;

  // Released level (1) is the reset state so no pulse fires out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

`ifdef WATCH_KEY_DEBOUNCE_EN
  localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;

  logic [CNT_W-1:0] cnt;

  // The counter runs only while the synchronised level disagrees with the
  // accepted level; any return to agreement restarts the window, so glitches
  // shorter than STABLE_CYC cycles never reach filt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      filt <= 1'b1;
    end else if (sync2 == filt) begin
      cnt  <= '0;
    end else if (cnt == CNT_W'(STABLE_CYC - 1)) begin
      cnt  <= '0;
      filt <= sync2;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end
`else
  assign filt = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) filt_prev <= 1'b1;
    else     filt_prev <= filt;
  end

  assign press = filt_prev & ~filt;

endmodule

// File: rtl/watch_data_gen.sv
// watch_data_gen
// 24-hour HH:MM watch with hidden seconds, a 1 Hz blinking LED and three
// buttons (mode / increment / decrement) for setting hours and minutes.
// Build option: WATCH_KEY_DEBOUNCE_EN adds a CLK_FRE/50-cycle (20 ms)
// stability filter on each key; the port list is the same either way.
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-high reset
//   key[2:0]     - active-low buttons: [0] mode, [1] increment, [2] decrement
//   hour_h_o     - hours tens digit (BCD)
//   hour_l_o     - hours units digit (BCD)
//   minutes_h_o  - minutes tens digit (BCD)
//   minutes_l_o  - minutes units digit (BCD)
//   second_led   - 1 Hz square wave, 50% duty
//   state_flag   - current mode: 0 RUN, 1 SET_HOUR, 2 SET_MINUTE
module watch_data_gen
  import watch_data_gen_pkg::*;
#(
  parameter int CLK_FRE = 12_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         key,
  output logic [DIGIT_W-1:0] hour_h_o,
  output logic [DIGIT_W-1:0] hour_l_o,
  output logic [DIGIT_W-1:0] minutes_h_o,
  output logic [DIGIT_W-1:0] minutes_l_o,
  output logic               second_led,
  output logic [2:0]         state_flag
);

  localparam int PRE_W = $clog2(CLK_FRE);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [2:0]       press;
  logic             mode_p;
  logic             inc_p;
  logic             dec_p;

  mode_e            mode_q, mode_nxt;
  logic [7:0]       hours_q, hours_nxt;
  logic [7:0]       mins_q, mins_nxt;
  logic [5:0]       sec_q, sec_nxt;

  // Key conditioning
  for (genvar i = 0; i < 3; i++) begin : g_key
`ifdef WATCH_KEY_DEBOUNCE_EN
    localparam int DB_CYC = (CLK_FRE / 50 > 0) ? CLK_FRE / 50 : 1;
    key_debounce #(.STABLE_CYC(DB_CYC)) u_key (
      .clk   (clk),
      .rst   (rst),
      .key   (key[i]),
      .press (press[i])
    );
`else
    key_debounce u_key (
      .clk   (clk),
      .rst   (rst),
      .key   (key[i]),
      .press (press[i])
    );
`endif
  end

  assign mode_p = press[0];
  assign inc_p  = press[1];
  assign dec_p  = press[2];

  // Prescaler and 1 Hz LED: free-running in every mode
  assign tick = (pre_cnt == PRE_W'(CLK_FRE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt    <= '0;
      second_led <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick || pre_cnt == PRE_W'(CLK_FRE / 2 - 1))
        second_led <= ~second_led;
    end
  end

  // Mode FSM and time update
  always_comb begin
    mode_nxt  = mode_q;
    hours_nxt = hours_q;
    mins_nxt  = mins_q;
    sec_nxt   = sec_q;
    case (mode_q)
      RUN: begin
        if (mode_p) mode_nxt = SET_HOUR;
        // The tick still lands on the edge that leaves RUN; freezing starts
        // from the next cycle. Edit keys are ignored here.
        if (tick) begin
          if (sec_q == 6'(SEC_MAX)) begin
            sec_nxt  = '0;
            mins_nxt = bcd_up(mins_q, MIN_MAX);
            if (mins_q == to_bcd(MIN_MAX))
              hours_nxt = bcd_up(hours_q, HOUR_MAX);
          end else begin
            sec_nxt = sec_q + 6'd1;
          end
        end
      end
      SET_HOUR: begin
        if (mode_p)              mode_nxt  = SET_MINUTE;
        else if (inc_p && !dec_p) hours_nxt = bcd_up(hours_q, HOUR_MAX);
        else if (dec_p && !inc_p) hours_nxt = bcd_down(hours_q, HOUR_MAX);
      end
      SET_MINUTE: begin
        // Minute edits wrap within the field and never touch hours.
        if (mode_p) begin
          mode_nxt = RUN;
          sec_nxt  = '0;
        end else if (inc_p && !dec_p) begin
          mins_nxt = bcd_up(mins_q, MIN_MAX);
        end else if (dec_p && !inc_p) begin
          mins_nxt = bcd_down(mins_q, MIN_MAX);
        end
      end
      default: mode_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= RUN;
      hours_q <= 8'h00;
      mins_q  <= 8'h00;
      sec_q   <= '0;
    end else begin
      mode_q  <= mode_nxt;
      hours_q <= hours_nxt;
      mins_q  <= mins_nxt;
      sec_q   <= sec_nxt;
    end
  end

  assign hour_h_o    = hours_q[7:4];
  assign hour_l_o    = hours_q[3:0];
  assign minutes_h_o = mins_q[7:4];
  assign minutes_l_o = mins_q[3:0];
  assign state_flag  = mode_q;

endmodule

// File: tb/tb_watch_data_gen.sv
// tb_watch_data_gen
// Directed bench for watch_data_gen at CLK_FRE=100: reset state, LED timing,
// a table of key presses with expected HH:MM and mode, then multi-cycle
// sequences for rollover, held keys, glitches and mid-edit reset.
module tb_watch_data_gen;

  localparam int CLK_FRE = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key;
  logic [3:0] hour_h_o, hour_l_o, minutes_h_o, minutes_l_o;
  logic       second_led;
  logic [2:0] state_flag;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  key;    // active-low pattern pressed together
    logic [15:0] hhmm;   // expected digits, BCD
    logic [2:0]  st;     // expected state_flag
  } vec_t;

  vec_t tbl[16];

  watch_data_gen #(.CLK_FRE(CLK_FRE)) dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .hour_h_o    (hour_h_o),
    .hour_l_o    (hour_l_o),
    .minutes_h_o (minutes_h_o),
    .minutes_l_o (minutes_l_o),
    .second_led  (second_led),
    .state_flag  (state_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {hour_h_o, hour_l_o, minutes_h_o, minutes_l_o};
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [2:0] pattern, input int hold);
    @(negedge clk);
    key = pattern;
    repeat (hold) @(negedge clk);
    key = 3'b111;
    repeat (6) @(negedge clk);
  endtask

  task automatic press_n(input logic [2:0] pattern, input int n);
    for (int i = 0; i < n; i++) press(pattern, 4);
  endtask

  // Counts falling LED edges, each of which coincides with a tick.
  task automatic wait_ticks(input int n);
    int   seen = 0;
    int   cyc  = 0;
    logic prev = second_led;
    while (seen < n && cyc < n * CLK_FRE + 200) begin
      @(posedge clk);
      #1;
      if (prev && !second_led) seen++;
      prev = second_led;
      cyc++;
    end
    check("tick_wait", seen, n);
  endtask

  initial begin
    tbl[0]  = '{3'b101, 16'h0000, 3'd0};  // inc in RUN ignored
    tbl[1]  = '{3'b110, 16'h0000, 3'd1};  // mode -> SET_HOUR
    tbl[2]  = '{3'b011, 16'h2300, 3'd1};  // dec 00 -> 23
    tbl[3]  = '{3'b011, 16'h2200, 3'd1};
    tbl[4]  = '{3'b011, 16'h2100, 3'd1};
    tbl[5]  = '{3'b001, 16'h2100, 3'd1};  // inc+dec together: no change
    tbl[6]  = '{3'b101, 16'h2200, 3'd1};
    tbl[7]  = '{3'b101, 16'h2300, 3'd1};
    tbl[8]  = '{3'b101, 16'h0000, 3'd1};  // 23 -> 00
    tbl[9]  = '{3'b100, 16'h0000, 3'd2};  // mode+inc: mode wins
    tbl[10] = '{3'b011, 16'h0059, 3'd2};  // minutes 00 -> 59
    tbl[11] = '{3'b101, 16'h0000, 3'd2};  // 59 -> 00, hours untouched
    tbl[12] = '{3'b011, 16'h0059, 3'd2};
    tbl[13] = '{3'b011, 16'h0058, 3'd2};
    tbl[14] = '{3'b101, 16'h0059, 3'd2};
    tbl[15] = '{3'b110, 16'h0059, 3'd0};  // back to RUN

    key = 3'b111;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_digits", digits(), 16'h0000);
    check("rst_state", state_flag, 0);
    check("rst_led", second_led, 0);
    rst = 1'b0;

    // LED toggles on the edges where the prescaler sits at 49 and 99.
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("led_c%0d", k), second_led, (k >= 49 && k < 99) ? 1 : 0);
    end
    check("run_digits", digits(), 16'h0000);

    for (int i = 0; i < 16; i++) begin
      press(tbl[i].key, 4);
      check($sformatf("vec%0d_digits", i), digits(), tbl[i].hhmm);
      check($sformatf("vec%0d_state", i), state_flag, tbl[i].st);
    end

    // Seconds were cleared on leaving SET_MINUTE: 59 ticks keep 00:59,
    // the 60th rolls to 01:00.
    wait_ticks(59);
    check("sec_clr_59", digits(), 16'h0059);
    wait_ticks(1);
    check("sec_clr_60", digits(), 16'h0100);

    // Preload 23:59 (seconds 0) and run to 23:59:59, then midnight.
    press(3'b110, 4);
    press_n(3'b011, 2);
    press(3'b110, 4);
    press(3'b011, 4);
    press(3'b110, 4);
    check("pre_digits", digits(), 16'h2359);
    check("pre_state", state_flag, 0);
    wait_ticks(59);
    check("pre_235959", digits(), 16'h2359);
    wait_ticks(1);
    check("midnight", digits(), 16'h0000);

    // Held increment: exactly one action.
    press(3'b110, 4);
    press(3'b101, 1000);
    check("held_digits", digits(), 16'h0100);
    check("held_state", state_flag, 1);

`ifdef WATCH_KEY_DEBOUNCE_EN
    // One-cycle glitch is shorter than the stability window.
    press(3'b101, 1);
    check("glitch", digits(), 16'h0100);
`endif

    // Mid-edit reset at 12:34 in SET_MINUTE.
    press_n(3'b101, 11);
    press(3'b110, 4);
    press_n(3'b101, 34);
    check("edit_digits", digits(), 16'h1234);
    check("edit_state", state_flag, 2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_digits", digits(), 16'h0000);
    check("arst_state", state_flag, 0);
    check("arst_led", second_led, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/watch_data_gen.md
WATCH_DATA_GEN -- requirements
Module: watch_data_gen

Interface
REQ-001 SHALL have parameter CLK_FRE, default 12_000_000, input clock frequency in Hz (minimum 4, even).
REQ-002 SHALL have port clk, input, 1 bit; the single system clock, all logic rising-edge.
REQ-003 SHALL have port rst, input, 1 bit; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port key, input, 3 bits, active-low raw buttons:
- key[0] = mode
- key[1] = increment
- key[2] = decrement
REQ-005 SHALL have ports hour_h_o, hour_l_o, minutes_h_o, minutes_l_o, each output, 4 bits, BCD time digits, registered.
REQ-006 SHALL have port second_led, output, 1 bit, 1 Hz square wave with 50% duty, registered.
REQ-007 SHALL have port state_flag, output, 3 bits, current mode, registered.

Function
REQ-008 SHALL run a prescaler counting 0..CLK_FRE-1 continuously in all modes.
- Tick pulse is 1 cycle, at count CLK_FRE-1.
REQ-009 SHALL toggle second_led when the prescaler reaches CLK_FRE/2-1 and again at CLK_FRE-1.
REQ-010 SHALL synchronise each key through 2 flops and generate a 1-cycle press pulse on the filtered high-to-low transition.
- A held key SHALL produce exactly one pulse.
REQ-011 SHALL encode state_flag as follows:
- 3'd0 RUN
- 3'd1 SET_HOUR
- 3'd2 SET_MINUTE
- any other value SHALL return to RUN on the next cycle.
REQ-012 SHALL advance the mode on a mode press: RUN -> SET_HOUR -> SET_MINUTE -> RUN.
REQ-013 In RUN, each tick SHALL increment seconds (0..59, internal, 6 bits).
- Seconds 59 -> 0 SHALL carry into minutes.
- Minutes 59 -> 00 SHALL carry into hours.
- Hours 23 -> 00 SHALL wrap with no further carry.
- 23:59:59 + tick SHALL give 00:00:00.
REQ-014 In SET_HOUR:
- Increment press: hours +1, 23 -> 00.
- Decrement press: hours -1, 00 -> 23.
- Seconds SHALL be frozen.
REQ-015 In SET_MINUTE:
- Increment press: minutes +1, 59 -> 00.
- Decrement press: minutes -1, 00 -> 59.
- Minute edits SHALL never carry or borrow into hours.
- Seconds SHALL be frozen.
REQ-016 Leaving SET_MINUTE for RUN SHALL clear seconds to 0.
REQ-017 Increment and decrement presses in RUN SHALL be ignored.
REQ-018 A mode press SHALL take priority; increment or decrement in the same cycle SHALL be ignored.
REQ-019 Simultaneous increment and decrement in the same cycle SHALL leave the time unchanged.
REQ-020 The digit outputs SHALL reflect an update one clock after the press pulse or tick.

Reset
REQ-021 On rst high, asynchronously and regardless of clock:
- time SHALL be 00:00 with seconds 0
- prescaler SHALL be 0
- second_led SHALL be 0
- state_flag SHALL be RUN
- synchronisers SHALL be 1 (released)
- debounce counters SHALL be 0.
REQ-022 Reset asserted mid-edit SHALL abandon the edit and return to RUN at 00:00.

Configuration
REQ-023 With macro WATCH_KEY_DEBOUNCE_EN defined, each synchronised key SHALL be accepted only after it is stable for CLK_FRE/50 cycles (20 ms).
REQ-024 Without WATCH_KEY_DEBOUNCE_EN, the synchronised key SHALL be used directly for edge detection.
- The port list SHALL be identical in both builds.

Structure
REQ-025 A shared package SHALL hold:
- the state_flag encodings (RUN, SET_HOUR, SET_MINUTE)
- the limit constants 23, 59 and 59
- the 4-bit BCD digit width.
REQ-026 A key_debounce sub-module SHALL be instantiated 3 times; it contains the synchroniser, the optional filter and the falling-edge pulse.
REQ-027 Expected implementation size is 150-300 lines of RTL.

Verification (CLK_FRE=100, debounce build uses 2-cycle stability)
REQ-028 Reset, then run 100 cycles: the bench SHALL see 1 tick; second_led toggles at cycle 49 and 99; digits 0,0,0,0.
REQ-029 Preload 23:59:59 via edits plus ticks, then 1 tick: the bench SHALL see 0,0,0,0.
REQ-030 Mode press, then 3 decrement presses from 00: the bench SHALL see state_flag 1 and hours 21 (2,1).
REQ-031 Mode twice, minutes at 59, increment: the bench SHALL see minutes 00 and hours unchanged; after a further mode press, state_flag 0 and seconds 0.
REQ-032 Key held low for 1000 cycles: the bench SHALL see exactly one action.
- Glitch shorter than the stability window (debounce build): the bench SHALL see no action.
REQ-033 Assert rst during SET_MINUTE with time 12:34: the bench SHALL see immediate outputs 0,0,0,0, state_flag 0 and second_led 0.
